// File: rtl/ifetch_pkg.sv
// ifetch_pkg: constants and FSM state type shared by the fetch unit, the PC and instruction memory.
package ifetch_pkg;
    localparam int FETCH_ADDR_W = 8;
    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_ADDR_LIMIT = 100;
    localparam int FETCH_TIMEOUT_CYC = 15;
    localparam logic [31:0] HALT_INSTR = 32'h00000073;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    typedef enum logic [2:0] {IDLE, CHECK, WAIT, OUT, DONE} state_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory read handshake plus instruction delivery toward decode.
interface ifetch_unit_if #(
    parameter int ADDR_W = ifetch_pkg::FETCH_ADDR_W,
    parameter int DATA_W = ifetch_pkg::FETCH_DATA_W
);
    logic mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic instr_valid;
    logic instr_ready;
    modport master(output mem_req, mem_addr, instr, instr_valid, input mem_ack, mem_rdata, instr_ready);
    modport slave(input mem_req, mem_addr, instr, instr_valid, output mem_ack, mem_rdata, instr_ready);
endinterface

// File: rtl/ifetch_timeout.sv
// ifetch_timeout: counts consecutive ack-less WAIT cycles and flags expiry on the TIMEOUT_CYC-th one.
module ifetch_timeout #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= active && !ack ? cnt + 1'b1 : '0;
    assign expired = active && !ack && cnt == CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC-driven instruction fetch sequencer (IDLE/CHECK/WAIT/OUT/DONE).
// Define FETCH_TIMEOUT_EN to add a mem_ack watchdog that faults after TIMEOUT_CYC cycles.
module ifetch_unit import ifetch_pkg::*; #(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int ADDR_LIMIT = FETCH_ADDR_LIMIT,
    parameter logic [DATA_W-1:0] HALT_INSTR = ifetch_pkg::HALT_INSTR,
    parameter int TIMEOUT_CYC = FETCH_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic pc_stall,
    output logic program_finished,
    output logic fetch_fault,
    ifetch_unit_if.master bus
);
    state_t state, next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] instr_q;
    logic valid_q, ack, misaligned, beyond, expired;
    assign ack = state == WAIT && bus.mem_ack;
    assign misaligned = addr_q[1:0] != 2'b00;
    assign beyond = addr_q >= ADDR_W'(ADDR_LIMIT);
`ifdef FETCH_TIMEOUT_EN
    ifetch_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk(clk),
        .rst(rst),
        .active(state == WAIT),
        .ack(bus.mem_ack),
        .expired(expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign expired = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = CHECK;
            CHECK:   next = misaligned || beyond ? DONE : WAIT;
            WAIT:    next = ack ? (bus.mem_rdata == HALT_INSTR ? DONE : OUT) : expired ? DONE : WAIT;
            OUT:     next = bus.instr_ready ? IDLE : OUT;
            default: next = DONE;
        endcase
    end
    // The halt word ends the program without ever reaching decode.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            program_finished <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            if (state == IDLE) addr_q <= pc_addr;
            if (state == WAIT && next == OUT) instr_q <= bus.mem_rdata;
            valid_q <= next == OUT;
            program_finished <= program_finished || next == DONE;
            fetch_fault <= fetch_fault || (state == CHECK && misaligned) || expired;
        end
    assign bus.mem_req = state == WAIT;
    assign bus.mem_addr = addr_q;
    assign bus.instr = instr_q;
    assign bus.instr_valid = valid_q;
    assign pc_stall = !(state == OUT && bus.instr_ready);
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and randomized checks of ifetch_unit against a program-level reference model.
module tb_ifetch_unit;
    import ifetch_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] pc_addr;
    logic pc_stall, program_finished, fetch_fault;
    ifetch_unit_if bus ();
    ifetch_unit dut (
        .clk(clk),
        .rst(rst),
        .pc_addr(pc_addr),
        .pc_stall(pc_stall),
        .program_finished(program_finished),
        .fetch_fault(fetch_fault),
        .bus(bus)
    );
    always #5 clk = ~clk;
    logic [31:0] mem [64];
    int total = 0, bad = 0, lat = 0, reqcyc = 0, wcnt = 0, pc = 0, fin_cyc = 0;
    bit lat_rnd = 1'b0, spur = 1'b0;
    int hs[$];
    logic [31:0] held;
    // Memory model: acks after `lat` request cycles; optionally fires stray acks when idle.
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (rst) wcnt = 0;
            else if (bus.mem_req) begin
                reqcyc++;
                if (wcnt >= lat) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr[7:2]];
                    wcnt = 0;
                    if (lat_rnd) lat = int'($urandom_range(0, 3));
                end else wcnt++;
            end else begin
                wcnt = 0;
                if (spur && $urandom_range(0, 7) == 0) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = $urandom;
                end
            end
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask
    // 0: word is delivered, 1: clean end of program, 2: fault
    function automatic int kind(input int p);
        if (p[1:0] != 2'b00) return 2;
        if (p >= 100) return 1;
        if (mem[p[7:2]] == HALT_INSTR) return 1;
        return 0;
    endfunction
    function automatic int next_pc(input int p, input bit rnd);
        int r;
        r = int'($urandom_range(0, 19));
        if (!rnd || r < 14) return p + 4 > 128 ? 128 : p + 4;
        if (r < 17) return 4 * int'($urandom_range(0, 24));
        if (r < 19) return 4 * int'($urandom_range(0, 24)) + int'($urandom_range(1, 3));
        return $urandom_range(0, 1) != 0 ? 128 : 100 + 4 * int'($urandom_range(0, 5));
    endfunction
    task automatic do_reset(input int p);
        rst = 1'b1;
        pc = p;
        pc_addr = 8'(p);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        reqcyc = 0;
    endtask
    task automatic run_prog(input bit rnd, input int budget);
        int cyc;
        cyc = 0;
        hs.delete();
        fin_cyc = -1;
        while (!program_finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rnd) bus.instr_ready = $urandom_range(0, 3) != 0;
            #1;
            if (bus.instr_valid && bus.instr_ready) begin
                chk("stall_on_handshake", pc_stall, 0);
                chk("delivery_expected", kind(pc), 0);
                chk("instr_word", bus.instr, mem[pc[7:2]]);
                hs.push_back(cyc);
                pc = next_pc(pc, rnd);
                pc_addr = 8'(pc);
            end else chk("stall_hold", pc_stall, 1);
            if (program_finished) fin_cyc = cyc;
        end
        chk("finish_in_budget", program_finished, 1);
        chk("end_reason", kind(pc) != 0, 1);
        chk("fault_flag", fetch_fault, kind(pc) == 2);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("done_stall", pc_stall, 1);
            chk("done_valid", bus.instr_valid, 0);
            chk("done_req", bus.mem_req, 0);
            chk("done_finished", program_finished, 1);
        end
    endtask
    initial begin
        bus.instr_ready = 1'b1;
        pc_addr = '0;
        foreach (mem[i]) mem[i] = NOP_INSTR;
        mem[0] = 32'h00500093;
        mem[1] = 32'h00A00113;
        mem[2] = 32'h002081B3;
        mem[3] = HALT_INSTR;
        mem[4] = 32'h00C00193;
        #1 rst = 1'b1;
        #2;
        chk("rst_stall", pc_stall, 1);
        chk("rst_instr", bus.instr, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_finished", program_finished, 0);
        chk("rst_fault", fetch_fault, 0);
        // Zero-wait program ending in ECALL.
        do_reset(0);
        run_prog(1'b0, 40);
        chk("prog_handshakes", hs.size(), 3);
        if (hs.size() == 3) begin
            chk("first_latency", hs[0], 3);
            chk("gap_1", hs[1] - hs[0], 4);
            chk("gap_2", hs[2] - hs[1], 4);
        end
        chk("halt_finish_cycle", fin_cyc, 15);
        // Delayed ack followed by decode back-pressure.
        do_reset(16);
        lat = 3;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wait_req", bus.mem_req, 1);
            chk("wait_addr", bus.mem_addr, 32'h10);
            chk("wait_stall", pc_stall, 1);
            chk("wait_valid", bus.instr_valid, 0);
            @(negedge clk);
        end
        #1;
        chk("ack_valid", bus.instr_valid, 1);
        chk("ack_instr", bus.instr, mem[4]);
        chk("ack_req_low", bus.mem_req, 0);
        held = bus.instr;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_instr", bus.instr, held);
            chk("bp_valid", bus.instr_valid, 1);
            chk("bp_stall", pc_stall, 1);
        end
        @(negedge clk);
        bus.instr_ready = 1'b1;
        #1;
        chk("ready_stall", pc_stall, 0);
        @(negedge clk);
        #1;
        chk("post_hs_stall", pc_stall, 1);
        chk("post_hs_valid", bus.instr_valid, 0);
        // Misaligned PC faults at the CHECK edge without a request.
        lat = 0;
        do_reset(6);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mis_fault", fetch_fault, 1);
        chk("mis_finished", program_finished, 1);
        repeat (3) @(negedge clk);
        chk("mis_no_req", reqcyc, 0);
        chk("mis_stall", pc_stall, 1);
        // End of program space, including a saturated PC.
        for (int k = 0; k < 2; k++) begin
            do_reset(k == 0 ? 128 : 100);
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("limit_finished", program_finished, 1);
            chk("limit_fault", fetch_fault, 0);
            repeat (3) @(negedge clk);
            chk("limit_no_req", reqcyc, 0);
        end
        // Asynchronous reset in the middle of a stalled fetch.
        do_reset(0);
        lat = 1000;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_req", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", bus.mem_req, 0);
        chk("async_valid", bus.instr_valid, 0);
        lat = 0;
        do_reset(0);
        run_prog(1'b0, 40);
        chk("restart_handshakes", hs.size(), 3);
`ifdef FETCH_TIMEOUT_EN
        do_reset(0);
        lat = 1000;
        for (int i = 0; i < 40 && !program_finished; i++) @(negedge clk);
        #1;
        chk("to_finished", program_finished, 1);
        chk("to_fault", fetch_fault, 1);
        chk("to_wait_cycles", reqcyc, 15);
        lat = 0;
`endif
        // Random programs, jumps, latencies, ready patterns and stray acks.
        lat_rnd = 1'b1;
        spur = 1'b1;
        repeat (25) begin
            for (int i = 0; i < 25; i++) begin
                mem[i] = $urandom;
                if (mem[i] == HALT_INSTR) mem[i] = NOP_INSTR;
            end
            if ($urandom_range(0, 1) != 0) mem[$urandom_range(0, 24)] = HALT_INSTR;
            lat = int'($urandom_range(0, 3));
            do_reset(4 * int'($urandom_range(0, 24)));
            run_prog(1'b1, 3000);
        end
        lat_rnd = 1'b0;
        spur = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
